// File: rtl/gate_checker.sv
// Self-test driver/checker for a 2-input gate: sweeps {a,b} through 00..11,
// waits SETTLE_CYCLES per vector and compares y_in with the TRUTH table.
module gate_checker #(
    parameter logic [3:0] TRUTH         = 4'b0111,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [7:0] CNT_LOAD   = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_SWEEP = 4'(PASSES - 1);

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [7:0]  cnt_q;
    logic [3:0]  sweep_q;
    logic        a_q, b_q, busy_q, done_q, pass_q;
    logic [3:0]  fail_mask_q, fail_mask_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        compare;
    logic        mismatch;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Result of the compare happening on this edge; pass must see it too.
    always_comb begin
        compare     = (state_q == S_SETTLE) && (cnt_q == 8'd0);
        mismatch    = (y_in != TRUTH[idx_q]);
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        if (compare && mismatch) begin
            fail_mask_d = fail_mask_q | (4'b0001 << idx_q);
            err_count_d = sat_inc(err_count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 8'd0;
            sweep_q     <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'd0;
            err_count_q <= 8'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_APPLY;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_mask_q <= 4'd0;
                        err_count_q <= 8'd0;
                        idx_q       <= 2'd0;
                        sweep_q     <= 4'd0;
                    end
                end
                S_APPLY: begin
                    a_q     <= idx_q[1];
                    b_q     <= idx_q[0];
                    cnt_q   <= CNT_LOAD;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        fail_mask_q <= fail_mask_d;
                        err_count_q <= err_count_d;
                        if (idx_q != 2'd3) begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= S_APPLY;
                        end else if (sweep_q != LAST_SWEEP) begin
                            idx_q   <= 2'd0;
                            sweep_q <= sweep_q + 4'd1;
                            state_q <= S_APPLY;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == 8'd0);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three configurations driven by table-defined gates,
// checked against an arithmetic model of vector timing and mismatch counts.
module tb_gate_checker;

    localparam int NU = 3;
    localparam int SETTLE_OF[NU] = '{4, 4, 1};
    localparam int PASSES_OF[NU] = '{1, 3, 15};
    localparam logic [3:0] TRUTH_REF = 4'b0111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start[NU];
    logic       y_in[NU];
    logic       a_o[NU], b_o[NU], busy[NU], done[NU], pass[NU];
    logic [3:0] fm[NU];
    logic [7:0] err[NU];
    logic [3:0] gate_tt[NU];

    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    // Attached "gates": output looked up from each instance's own a/b.
    assign y_in[0] = gate_tt[0][{a_o[0], b_o[0]}];
    assign y_in[1] = gate_tt[1][{a_o[1], b_o[1]}];
    assign y_in[2] = gate_tt[2][{a_o[2], b_o[2]}];

    gate_checker u_def (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .y_in(y_in[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail_mask(fm[0]), .err_count(err[0])
    );

    gate_checker #(.TRUTH(4'b0111), .SETTLE_CYCLES(4), .PASSES(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .y_in(y_in[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail_mask(fm[1]), .err_count(err[1])
    );

    gate_checker #(.TRUTH(4'b0111), .SETTLE_CYCLES(1), .PASSES(15)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .y_in(y_in[2]),
        .a_out(a_o[2]), .b_out(b_o[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .fail_mask(fm[2]), .err_count(err[2])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode: 0 pulse, 1 hold start through run and into following IDLE,
    //       2 extra start pulse mid-run, 4 pulse plus forced err_count base
    task automatic run(input int u, input int mode, input bit prestarted, input int force_base);
        int         s, p, n, dones, exp_err;
        logic [3:0] mism;
        logic [1:0] vi;
        bit         exp_pass;
        s        = SETTLE_OF[u];
        p        = PASSES_OF[u];
        n        = 4 * p * (s + 1) + 1;
        mism     = gate_tt[u] ^ TRUTH_REF;
        exp_err  = force_base + p * $countones(mism);
        if (exp_err > 255) exp_err = 255;
        exp_pass = (exp_err == 0);
        dones    = 0;
        if (!prestarted) begin
            @(negedge clk);
            start[u] = 1'b1;
        end
        // Interval k follows edge T+k, T being the start edge (cycle 1).
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (done[u]) dones++;
            if (k == 0) begin
                check_val("start_clear", 32'({busy[u], done[u], pass[u], fm[u], err[u]}),
                          32'({1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
                if (mode != 1) start[u] = 1'b0;
                if (mode == 4) begin
                    force u_s1.err_count_q = 8'(force_base);
                    #1;
                    release u_s1.err_count_q;
                end
            end else if (k < n) begin
                vi = 2'(((k - 1) / (s + 1)) % 4);
                check_val("seq_ab_busy_done", 32'({a_o[u], b_o[u], busy[u], done[u]}),
                          32'({vi, 1'b1, (k == n - 1)}));
                if (k == n - 1) begin
                    check_val("fail_mask", 32'(fm[u]), 32'(mism));
                    check_val("err_count", 32'(err[u]), 32'(exp_err));
                    check_val("pass", 32'(pass[u]), 32'(exp_pass));
                end
                if (mode == 2 && k == n / 2) start[u] = 1'b1;
                if (mode == 2 && k == n / 2 + 1) start[u] = 1'b0;
            end else begin
                check_val("idle_after", 32'({a_o[u], b_o[u], busy[u], done[u], pass[u], fm[u], err[u]}),
                          32'({2'b11, 1'b0, 1'b0, exp_pass, mism, 8'(exp_err)}));
            end
        end
        check_val("done_pulses", 32'(dones), 32'd1);
    endtask

    task automatic reset_mid();
        int s, dn;
        s = SETTLE_OF[0];
        @(negedge clk);
        start[0] = 1'b1;
        for (int k = 0; k <= 2 * (s + 1) + 2; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        check_val("mid_vector", 32'({a_o[0], b_o[0], busy[0]}), 32'({2'b10, 1'b1}));
        rst_n = 1'b0;
        #1;
        check_val("async_reset", 32'({a_o[0], b_o[0], busy[0], done[0], pass[0], fm[0], err[0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done[0] || busy[0]) dn++;
        end
        check_val("no_done_after_abort", 32'(dn), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < NU; i++) begin
            start[i]   = 1'b0;
            gate_tt[i] = 4'b0111;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NU; i++)
            check_val("reset_outputs", 32'({a_o[i], b_o[i], busy[i], done[i], pass[i], fm[i], err[i]}), 32'd0);
        rst_n = 1'b1;

        gate_tt[0] = 4'b0111;               // real NAND
        run(0, 0, 1'b0, 0);
        gate_tt[0] = 4'b1111;               // stuck at 1
        run(0, 0, 1'b0, 0);
        gate_tt[1] = 4'b1000;               // AND on the 3-pass instance
        run(1, 0, 1'b0, 0);

        gate_tt[0] = 4'b0111;
        reset_mid();
        run(0, 0, 1'b0, 0);

        gate_tt[0] = 4'b0110;
        run(0, 1, 1'b0, 0);                 // start held: second run launched from IDLE
        run(0, 0, 1'b1, 0);
        run(0, 2, 1'b0, 0);

        gate_tt[2] = 4'b0000;               // stuck at 0, 15 sweeps
        run(2, 0, 1'b0, 0);
        run(2, 4, 1'b0, 250);               // saturation from forced base

        for (int i = 0; i < 10; i++) begin
            int u;
            u = (i % 4 == 3) ? 1 : 0;
            gate_tt[u] = 4'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(u, 0, 1'b0, 0);
        end
        gate_tt[2] = 4'($urandom);
        run(2, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
